// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory,
// holding the CPU until the last word has been written.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN0  = 3'd1;
  localparam logic [2:0] LEN1  = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] FLUSH = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  localparam logic [33:0] CAP = 34'(MEM_BYTES) - 34'(BASE_ADDR);
  localparam logic [31:0] IDLE_MAX = 32'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [15:0] n_len;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [31:0] idle_cnt;
  logic        accept;
  logic        timeout;
  logic        last_word;
  logic [15:0] n_new;
  logic [33:0] need;

  assign byte_ready = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign accept     = byte_valid && byte_ready;
  assign timeout    = byte_ready && !accept && (idle_cnt == IDLE_MAX);
  assign last_word  = (words_loaded + 16'd1) == n_len;
  assign n_new      = {byte_data, n_len[7:0]};
  assign need       = {16'b0, n_new, 2'b00};

  assign cpu_hold = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);
  assign error    = (state == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      n_len        <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      idle_cnt     <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we   <= 1'b0;
      idle_cnt <= (byte_ready && !accept) ? idle_cnt + 32'd1 : 32'd0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN0;
            words_loaded <= '0;
            byte_idx     <= '0;
            word_buf     <= '0;
          end
        end
        LEN0: begin
          if (accept) begin
            n_len[7:0] <= byte_data;
            state      <= LEN1;
          end else if (timeout) begin
            state <= ERR;
          end
        end
        LEN1: begin
          if (accept) begin
            n_len[15:8] <= byte_data;
            if (need > CAP)
              state <= ERR;
            else if (n_new == 16'd0)
              state <= DONE;
            else
              state <= DATA;
          end else if (timeout) begin
            state <= ERR;
          end
        end
        DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= byte_data;
              2'd1: word_buf[15:8]  <= byte_data;
              2'd2: word_buf[23:16] <= byte_data;
              default: begin
                // 4th byte completes the word; ready stays up unless it is the last
                mem_we       <= 1'b1;
                mem_addr     <= BASE_ADDR + {14'b0, words_loaded, 2'b00};
                mem_wdata    <= {byte_data, word_buf};
                words_loaded <= words_loaded + 16'd1;
                if (last_word)
                  state <= FLUSH;
              end
            endcase
          end else if (timeout) begin
            state <= ERR;
          end
        end
        FLUSH: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed vector bench for imem_loader: table of loads plus
// timeout and mid-load reset sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(
    .BASE_ADDR(32'h0000_0000),
    .MEM_BYTES(65536),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic        wr_rdy[$];

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
      wr_rdy.push_back(byte_ready);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    wr_rdy.delete();
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!byte_ready) begin
      failures++;
      $display("FAIL send_byte: byte_ready never rose for %h", b);
    end
    @(negedge clk);
  endtask

  typedef struct {
    string            name;
    int               nb;
    logic [15:0][7:0] b;
    logic             e_done;
    logic             e_err;
    logic [15:0]      e_words;
    int               e_nw;
    logic [31:0]      e_a0;
    logic [31:0]      e_d0;
    logic [31:0]      e_al;
    logic [31:0]      e_dl;
  } vec_t;

  function automatic vec_t mk(input string name, input int nb,
                              input logic [127:0] bytes,
                              input logic e_done, input logic e_err,
                              input logic [15:0] e_words, input int e_nw,
                              input logic [31:0] e_a0, input logic [31:0] e_d0,
                              input logic [31:0] e_al, input logic [31:0] e_dl);
    vec_t v;
    v.name = name;
    v.nb = nb;
    v.b = bytes;
    v.e_done = e_done;
    v.e_err = e_err;
    v.e_words = e_words;
    v.e_nw = e_nw;
    v.e_a0 = e_a0;
    v.e_d0 = e_d0;
    v.e_al = e_al;
    v.e_dl = e_dl;
    return v;
  endfunction

  task automatic run_load(input vec_t v);
    int t;
    int dcyc;
    int last;
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, "_hold_on_start"}, 32'(cpu_hold), 32'd1);
    chk({v.name, "_words_cleared"}, 32'(words_loaded), 32'd0);
    for (int i = 0; i < v.nb; i++) send_byte(v.b[15-i]);
    byte_valid = 1'b0;
    t = 0;
    while (!(done || error) && t < 20) begin
      @(negedge clk);
      t++;
    end
    dcyc = cyc;
    chk({v.name, "_done"}, 32'(done), 32'(v.e_done));
    chk({v.name, "_error"}, 32'(error), 32'(v.e_err));
    chk({v.name, "_cpu_hold"}, 32'(cpu_hold), 32'(v.e_err));
    chk({v.name, "_words"}, 32'(words_loaded), 32'(v.e_words));
    chk({v.name, "_nwrites"}, 32'(wr_addr.size()), 32'(v.e_nw));
    if (wr_addr.size() == v.e_nw && v.e_nw > 0) begin
      last = v.e_nw - 1;
      chk({v.name, "_addr0"}, wr_addr[0], v.e_a0);
      chk({v.name, "_data0"}, wr_data[0], v.e_d0);
      chk({v.name, "_addr_last"}, wr_addr[last], v.e_al);
      chk({v.name, "_data_last"}, wr_data[last], v.e_dl);
      chk({v.name, "_ready_low_flush"}, 32'(wr_rdy[last]), 32'd0);
      chk({v.name, "_done_lat"}, 32'(dcyc - wr_cyc[last]), 32'd1);
      if (v.e_nw > 1) begin
        chk({v.name, "_b2b_spacing"}, 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
        chk({v.name, "_ready_during_wr"}, 32'(wr_rdy[0]), 32'd1);
      end
    end
    repeat (3) @(negedge clk);
    chk({v.name, "_no_stray_we"}, 32'(wr_addr.size()), 32'(v.e_nw));
    chk({v.name, "_flags_held"}, 32'({done, error}),
        32'({v.e_done, v.e_err}));
  endtask

  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = mk("one_word", 6,
               {8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 80'h0},
               1'b1, 1'b0, 16'd1, 1,
               32'h0, 32'h00100513, 32'h0, 32'h00100513);
    vt[1] = mk("two_words", 10,
               {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                8'h55, 8'h66, 8'h77, 8'h88, 48'h0},
               1'b1, 1'b0, 16'd2, 2,
               32'h0, 32'h44332211, 32'h4, 32'h88776655);
    vt[2] = mk("zero_len", 2, {8'h00, 8'h00, 112'h0},
               1'b1, 1'b0, 16'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    vt[3] = mk("too_long", 2, {8'h01, 8'h40, 112'h0},
               1'b0, 1'b1, 16'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    vt[4] = mk("max_len", 2, {8'hff, 8'hff, 112'h0},
               1'b0, 1'b1, 16'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    vt[5] = mk("three_words", 14,
               {8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                8'ha0, 8'hb0, 8'hc0, 8'hd0,
                8'hde, 8'had, 8'hbe, 8'hef, 16'h0},
               1'b1, 1'b0, 16'd3, 3,
               32'h0, 32'h04030201, 32'h8, 32'hefbeadde);

    #12;
    chk("reset_ctrl", 32'({byte_ready, mem_we, cpu_hold, done, error}), 32'd0);
    chk("reset_words", 32'(words_loaded), 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_hold", 32'({cpu_hold, byte_ready}), 32'd0);

    for (int i = 0; i < 6; i++) run_load(vt[i]);

    // idle timeout after the 3rd data byte
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    byte_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("timeout_not_yet", 32'(error), 32'd0);
    @(negedge clk);
    chk("timeout_error", 32'(error), 32'd1);
    chk("timeout_hold", 32'(cpu_hold), 32'd1);
    chk("timeout_no_write", 32'(wr_addr.size()), 32'd0);

    // reset mid-DATA, then a clean load straight out of reset
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'haa);
    send_byte(8'hbb);
    byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", 32'({byte_ready, mem_we, cpu_hold, done, error}), 32'd0);
    chk("midrst_words", 32'(words_loaded), 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_load(vt[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written; word-aligned.
REQ-002 SHALL have parameter MEM_BYTES, default 65536: instruction memory capacity in bytes.
REQ-003 SHALL have parameter TIMEOUT, default 100000: maximum idle cycles allowed between accepted bytes while loading; value is at least 2.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin a load.
REQ-007 SHALL have port byte_valid, input, 1: byte_data holds a valid byte.
REQ-008 SHALL have port byte_data, input, 8: incoming stream byte.
REQ-009 SHALL have port byte_ready, output, 1: the loader accepts a byte in this cycle.
REQ-010 SHALL have port mem_we, output, 1: one-cycle write strobe to the instruction memory write port.
REQ-011 SHALL have port mem_addr, output, 32: byte address of the write; always word-aligned.
REQ-012 SHALL have port mem_wdata, output, 32: write word; byte k of the word occupies bits 8k+7:8k (little-endian).
REQ-013 SHALL have port cpu_hold, output, 1: holds the pipeline while instruction memory is being loaded.
REQ-014 SHALL have ports done, output, 1 and error, output, 1: level status flags.
REQ-015 SHALL have port words_loaded, output, 16: count of words written in the current load.

Function
REQ-016 SHALL implement the states IDLE, LEN0, LEN1, DATA, FLUSH, DONE and ERR.
REQ-017 SHALL accept a byte only on a cycle where byte_valid and byte_ready are both high; byte_ready is high only in LEN0, LEN1 and DATA.
REQ-018 On start in IDLE, DONE or ERR, SHALL go to LEN0, clear done, error and words_loaded, and assert cpu_hold; start in any other state is ignored.
REQ-019 SHALL take the byte accepted in LEN0 as N[7:0] (then go to LEN1) and the byte accepted in LEN1 as N[15:8].
REQ-020 After LEN1, SHALL go to ERR if N*4 > MEM_BYTES - BASE_ADDR, to FLUSH-free DONE if N == 0, and to DATA otherwise.
REQ-021 In DATA, SHALL pack accepted bytes into a word, first byte into bits 7:0.
REQ-022 On the edge accepting the 4th byte of word k, SHALL register mem_we=1, mem_addr=BASE_ADDR+4k and the packed mem_wdata, and increment words_loaded; mem_we is high for exactly one cycle.
REQ-023 For words other than the last, SHALL keep byte_ready high during the write cycle, so the next byte is accepted back-to-back without loss.
REQ-024 After the 4th byte of word N-1, SHALL go to FLUSH; byte_ready is low in FLUSH and mem_we is high there.
REQ-025 From FLUSH, SHALL go to DONE on the next edge: done=1 and cpu_hold=0 only after the last write has been issued.
REQ-026 SHALL hold mem_addr and mem_wdata when mem_we is low.
REQ-027 SHALL run an idle counter in LEN0, LEN1 and DATA, cleared on every accepted byte and on state entry.
REQ-028 When the idle counter reaches TIMEOUT-1 with no byte accepted, SHALL go to ERR.
REQ-029 In ERR, SHALL set error=1 and hold cpu_hold=1 until the next start or reset; no mem_we is issued in ERR.
REQ-030 In DONE, SHALL keep done=1 and words_loaded=N until the next start.
REQ-031 In IDLE, SHALL keep cpu_hold=0, so the CPU can run from preloaded memory contents.

Reset
REQ-032 On rst high, SHALL go immediately to IDLE and clear every output (byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_loaded) to 0, including partially assembled words.
REQ-033 On the first clk edge after rst falls, SHALL respond to start with no extra delay.

Verification
REQ-034 Bench SHALL cover: start, bytes 01 00 13 05 10 00 -> one mem_we with addr 0x0 and wdata 0x00100513; one cycle later done=1, cpu_hold=0, words_loaded=1.
REQ-035 Bench SHALL cover: N=2, 8 bytes back-to-back with byte_valid held high -> writes at 0x0 and 0x4, no lost byte, cpu_hold falls one cycle after the second mem_we.
REQ-036 Bench SHALL cover: bytes 00 00 -> DONE, no mem_we; and bytes 01 40 (N=0x4001) with MEM_BYTES=65536 -> error=1, cpu_hold=1, no mem_we.
REQ-037 Bench SHALL cover: TIMEOUT=16, byte_valid held low for 16 cycles after the 3rd data byte -> error=1, no write.
REQ-038 Bench SHALL cover: rst pulsed mid-DATA, then a new full load -> all outputs 0 during reset, and the new load's first write is at BASE_ADDR with no stale bytes.
